precomp_scheduler: RTL and testbench

PRECOMP_SCHEDULER -- requirements
Module: precomp_scheduler

---
 rtl/precomp_scheduler_pkg.sv | 19 +
 rtl/precomp_scheduler_arb.sv | 28 ++
 rtl/precomp_scheduler.sv | 99 +++++++++
 tb/tb_precomp_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/precomp_scheduler_pkg.sv
// Shared types and constants for the precompute job scheduler.
package precomp_scheduler_pkg;

   localparam int OP_W            = 1024;
   localparam int TIMEOUT_DEFAULT = 2047;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_START  = 2'd1,
      S_WAIT   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   // Counter width that can hold 0..t inclusive.
   function automatic int cnt_width(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/precomp_scheduler_arb.sv
// Two-input round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] grant
);

   // High when B was granted last, so A wins the next tie (reset value favours A).
   logic last_b;

   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || last_b))
         grant = 2'b01;
      else if (req[1])
         grant = 2'b10;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last_b <= 1'b1;
      else if (en && (|req))
         last_b <= grant[1];
   end

endmodule

// File: rtl/precomp_scheduler.sv
// Schedules jobs from two requesters onto one shared 1x/2x/3x shift-add datapath,
// with a WAIT-state timeout that aborts a job whose datapath never answers.
module precomp_scheduler
   import precomp_scheduler_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            a_req,
   input  logic [OP_W-1:0] a_operand,
   input  logic            b_req,
   input  logic [OP_W-1:0] b_operand,
   output logic            dp_start,
   output logic [OP_W-1:0] dp_operand,
   input  logic            dp_done,
   output logic            a_done,
   output logic            b_done,
   output logic            a_err,
   output logic            b_err,
   output logic            busy
);

   localparam int            CW      = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          own_b;
   logic [1:0]    grant;
   logic          arb_en;

   assign arb_en = (state == S_IDLE);

   rr_arb2 u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    ({b_req, a_req}),
      .en     (arb_en),
      .grant  (grant)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         own_b      <= 1'b0;
         dp_start   <= 1'b0;
         dp_operand <= '0;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
         a_err      <= 1'b0;
         b_err      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         dp_start <= 1'b0;
         a_done   <= 1'b0;
         b_done   <= 1'b0;
         a_err    <= 1'b0;
         b_err    <= 1'b0;
         case (state)
            S_IDLE: begin
               // dp_operand is only written here, so it stays stable for the whole job.
               if (|grant) begin
                  own_b      <= grant[1];
                  dp_operand <= grant[1] ? b_operand : a_operand;
                  dp_start   <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // dp_done is tested first so it beats a timeout in the same cycle.
               if (dp_done) begin
                  a_done <= ~own_b;
                  b_done <= own_b;
                  state  <= S_FINISH;
               end else if (cnt == CNT_MAX) begin
                  a_err <= ~own_b;
                  b_err <= own_b;
                  state <= S_FINISH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_FINISH: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_precomp_scheduler.sv
// Directed bench for precomp_scheduler: job-level reference model checked every cycle,
// plus literal latency / ordering expectations per scenario.
module tb_precomp_scheduler;

   localparam int TO   = 15;
   localparam int OPW  = 1024;

   logic            clk = 1'b0;
   logic            resetn;
   logic            a_req, b_req;
   logic [OPW-1:0]  a_operand, b_operand;
   logic            dp_start, dp_done;
   logic [OPW-1:0]  dp_operand;
   logic            a_done, b_done, a_err, b_err, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   precomp_scheduler #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .a_req      (a_req),
      .a_operand  (a_operand),
      .b_req      (b_req),
      .b_operand  (b_operand),
      .dp_start   (dp_start),
      .dp_operand (dp_operand),
      .dp_done    (dp_done),
      .a_done     (a_done),
      .b_done     (b_done),
      .a_err      (a_err),
      .b_err      (b_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_op(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got ..%0h expected ..%0h (low 64 bits)", name, cyc,
                  act[63:0], exp[63:0]);
      end
   endtask

   // Datapath stand-in: dp_done pulses dp_lat cycles after dp_start (0 = never answers).
   int dp_lat = 0;
   int cd     = 0;
   bit stray  = 0;
   always @(negedge clk) begin
      dp_done = 1'b0;
      if (!resetn) cd = 0;
      else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) dp_done = 1'b1;
         end
         if (dp_start && dp_lat > 0) cd = dp_lat;
      end
      if (stray) begin
         dp_done = 1'b1;
         stray   = 0;
      end
   end

   // Reference model: a job is "granted", then one start cycle, then waits until the
   // datapath answers or TO+1 wait cycles elapse, then one finish cycle.
   bit             m_job = 0;       // a job is in flight
   int             m_age = 0;       // 1 = start cycle, 2.. = wait cycles, -1 = finish
   int             m_waited = 0;
   bit             m_own_b = 0, m_last_b = 1, m_err = 0;
   logic [OPW-1:0] m_op = '0;
   int             start_cyc = -1, done_cyc = -1, err_cyc = -1, n_done = 0, n_err = 0;
   bit             done_q[$];

   always @(posedge clk) begin
      cyc++;
      if (!resetn) begin
         m_job = 0; m_last_b = 1; m_op = '0;
      end else if (!m_job) begin
         if (a_req || b_req) begin
            m_own_b  = b_req && (!a_req || !m_last_b);
            m_last_b = m_own_b;
            m_op     = m_own_b ? b_operand : a_operand;
            m_job    = 1;
            m_age    = 1;
         end
      end else if (m_age == 1) begin
         m_age = 2; m_waited = 0;
      end else if (m_age == -1) begin
         m_job = 0;
      end else begin
         if (dp_done)            begin m_age = -1; m_err = 0; end
         else if (m_waited == TO) begin m_age = -1; m_err = 1; end
         else m_waited++;
      end
      #1;
      if (resetn) begin
         chk("busy",     64'(busy),     64'(m_job));
         chk("dp_start", 64'(dp_start), 64'(m_job && m_age == 1));
         chk("a_done",   64'(a_done),   64'(m_job && m_age == -1 && !m_err && !m_own_b));
         chk("b_done",   64'(b_done),   64'(m_job && m_age == -1 && !m_err &&  m_own_b));
         chk("a_err",    64'(a_err),    64'(m_job && m_age == -1 &&  m_err && !m_own_b));
         chk("b_err",    64'(b_err),    64'(m_job && m_age == -1 &&  m_err &&  m_own_b));
         chk_op("dp_operand", dp_operand, m_op);
      end
      if (dp_start) start_cyc = cyc;
      if (a_done || b_done) begin done_cyc = cyc; n_done++; done_q.push_back(b_done); end
      if (a_err || b_err) begin err_cyc = cyc; n_err++; end
   end

   // Returns at the falling edge inside the finish cycle, so callers can drop req there.
   task automatic wait_end(input int max);
      bit got = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (a_done || b_done || a_err || b_err) begin
            got = 1;
            break;
         end
      end
      chk("job_ended", 64'(got), 64'(1));
   endtask

   int             e, nd;
   logic [OPW-1:0] opa, opb;

   initial begin
      resetn = 0; a_req = 0; b_req = 0; a_operand = '0; b_operand = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_dp_start", 64'(dp_start), 0);
      chk("rst_dones", 64'({a_done, b_done, a_err, b_err}), 0);
      chk_op("rst_operand", dp_operand, '0);
      resetn = 1;
      @(negedge clk);

      // Single job, datapath answers after 10 cycles.
      a_operand = OPW'(5); a_req = 1; dp_lat = 10; e = cyc + 1;
      wait_end(40);
      chk("t1_a_done", 64'(a_done), 1);
      chk("t1_b_done", 64'(b_done), 0);
      chk("t1_start_cyc", 64'(start_cyc), 64'(e));
      chk("t1_done_cyc", 64'(done_cyc), 64'(e + 11));
      chk_op("t1_operand", dp_operand, OPW'(5));
      a_req = 0;
      @(negedge clk);
      chk("t1_idle", 64'(busy), 0);

      // Timeout: no answer, error after 16 wait cycles.
      a_operand = {32{32'hDEADBEEF}}; a_req = 1; dp_lat = 0; e = cyc + 1;
      wait_end(40);
      chk("t2_a_err", 64'(a_err), 1);
      chk("t2_a_done", 64'(a_done), 0);
      chk("t2_err_cyc", 64'(err_cyc), 64'(e + 17));
      a_req = 0;
      @(negedge clk);
      chk("t2_idle", 64'(busy), 0);

      // Answer lands on the same cycle the counter hits TIMEOUT: done wins.
      b_operand = {16{64'h0123_4567_89AB_CDEF}}; b_req = 1; dp_lat = 16; e = cyc + 1;
      nd = n_err;
      wait_end(40);
      chk("t3_b_done", 64'(b_done), 1);
      chk("t3_b_err", 64'(b_err), 0);
      chk("t3_done_cyc", 64'(done_cyc), 64'(e + 17));
      b_req = 0;
      @(negedge clk);
      chk("t3_no_err", 64'(n_err), 64'(nd));

      // A drops req mid-job; B requests meanwhile and is served afterwards.
      a_operand = OPW'(32'hA5A5); a_req = 1; dp_lat = 4;
      repeat (2) @(negedge clk);
      a_req = 0; b_req = 1; b_operand = OPW'(32'h5A5A);
      wait_end(20);
      chk("t4_a_done", 64'(a_done), 1);
      wait_end(20);
      chk("t4_b_done", 64'(b_done), 1);
      chk_op("t4_b_operand", dp_operand, OPW'(32'h5A5A));
      b_req = 0;
      @(negedge clk);

      // Contention from reset: A, then B, then A again.
      resetn = 0; a_req = 1; b_req = 1; dp_lat = 2;
      opa = {8{128'h1111_2222_3333_4444_5555_6666_7777_8888}};
      opb = {8{128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000}};
      a_operand = opa; b_operand = opb;
      repeat (2) @(negedge clk);
      resetn = 1;
      done_q.delete();
      wait_end(20);
      chk_op("t5_op1", dp_operand, opa);
      wait_end(20);
      chk_op("t5_op2", dp_operand, opb);
      wait_end(20);
      chk_op("t5_op3", dp_operand, opa);
      a_req = 0; b_req = 0;
      chk("t5_n", 64'(done_q.size()), 3);
      if (done_q.size() == 3) begin
         chk("t5_order0", 64'(done_q[0]), 0);
         chk("t5_order1", 64'(done_q[1]), 1);
         chk("t5_order2", 64'(done_q[2]), 0);
      end
      @(negedge clk);

      // Reset mid-wait: everything clears at once, no pulse, A favoured afterwards.
      nd = n_done + n_err;
      a_operand = OPW'(7); a_req = 1; dp_lat = 0;
      repeat (5) @(negedge clk);
      resetn = 0; a_req = 0;
      #1;
      chk("t6_busy", 64'(busy), 0);
      chk("t6_dp_start", 64'(dp_start), 0);
      chk("t6_dones", 64'({a_done, b_done, a_err, b_err}), 0);
      chk_op("t6_operand", dp_operand, '0);
      repeat (2) @(negedge clk);
      chk("t6_no_pulse", 64'(n_done + n_err), 64'(nd));
      resetn = 1; a_req = 1; b_req = 1; a_operand = opa; b_operand = opb; dp_lat = 3;
      wait_end(20);
      chk("t6_a_first", 64'(a_done), 1);
      chk_op("t6_a_op", dp_operand, opa);
      a_req = 0;
      wait_end(20);
      chk("t6_b_next", 64'(b_done), 1);
      b_req = 0;
      @(negedge clk);

      // Stray datapath pulse while idle.
      nd = n_done;
      stray = 1;
      repeat (4) @(negedge clk);
      chk("t7_idle", 64'(busy), 0);
      chk("t7_no_done", 64'(n_done), 64'(nd));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
